sample_capture_buf: RTL and testbench
=====================================

Name: sample_capture_buf

Overview:
- Upstream stage of the correlation engine. Captures a stream of signed 8-bit received samples into a DEPTH-entry buffer.
- Once full, pulses start to the correlator, then serves its random reads (pointA index i+y) until the correlator reports done via its rdy output.
- Replaces the fixed file-loaded sample memory with a live, re-armable capture.

Parameters:
- DEPTH, 5000, samples per capture (correlator scans indices 0..DEPTH-1).
- DW, 8, sample width, signed two's complement.
- AW, 13, address width; must satisfy 2**AW >= DEPTH.
- TRIG_LEVEL, 32, magnitude threshold used only when CAP_TRIG_EN is defined.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, synchronous, active-low (asserted when rst=0, sampled on rising clk).
- ena  in  1  clock enable; when 0, all state holds, s_ready=0 and start_out=0.
- arm  in  1  single-cycle request to begin a new capture.
- s_valid  in  1  input sample valid.
- s_data  in  DW  input sample, signed.
- s_ready  out  1  buffer accepts a sample this cycle.
- rd_addr  in  AW  correlator read address.
- rd_data  out  DW  read data, registered, 1-cycle latency.
- corr_rdy  in  1  correlator done pulse (its rdy); releases the buffer.
- start_out  out  1  one-cycle pulse to the correlator start input.
- full  out  1  buffer holds a complete capture.
- count  out  AW  number of samples written in the current capture.
- ovf  out  1  sticky: a sample was offered while not accepted in SERVE.

Behaviour:
- Reset values (rst=0 at a clock edge): state=IDLE, count=0, full=0, start_out=0, ovf=0, rd_data=0, s_ready=0. Reset mid-capture discards the partial capture. No arm is remembered across reset.
- All transitions and updates happen only when ena=1.
- State machine:
  - IDLE: s_ready=0. arm → FILL, with count:=0 and ovf:=0.
  - FILL: s_ready=1. On s_valid&s_ready, write s_data at address count, then count:=count+1. When the write with count==DEPTH-1 occurs → HANDOFF. arm is ignored.
  - HANDOFF: one cycle. start_out=1, full=1, s_ready=0 → SERVE.
  - SERVE: s_ready=0, full=1. If s_valid=1, set ovf:=1 (the sample is dropped). corr_rdy=1 → IDLE with full:=0. arm is ignored.
- Handshake: a sample transfers only on a cycle with s_valid=1 and s_ready=1. Gaps in s_valid stall FILL indefinitely with no timeout.
- Read port:
  - In SERVE or HANDOFF, rd_data at edge n+1 = mem[rd_addr sampled at edge n].
  - rd_addr >= DEPTH returns 0.
  - In IDLE and FILL, rd_data=0.
- Simultaneous events:
  - arm and corr_rdy in the same SERVE cycle: go to IDLE; the arm is dropped. The source must re-arm.
  - corr_rdy outside SERVE is ignored.
- count saturates at DEPTH and holds its value through SERVE; it is cleared only by the next arm.
- Storage: a single-port-write, single-port-read synchronous RAM, DEPTH x DW, inferrable as block RAM. Memory contents are not cleared by reset.

Optional Feature:
- Macro: CAP_TRIG_EN.
- Defined:
  - FILL starts in a pre-trigger sub-phase: s_ready=1, but samples with |s_data| < TRIG_LEVEL are accepted and discarded, and count stays 0.
  - The first sample with |s_data| >= TRIG_LEVEL is written at address 0 and capture proceeds normally.
  - |−128| is treated as 128.
- Undefined: capture begins with the first accepted sample after arm; TRIG_LEVEL is unused.

Decomposition:
- Shared package (corr_pkg): DW, AW, DEPTH, state encoding constants (IDLE, FILL, HANDOFF, SERVE), and the signed sample typedef. The correlator uses the same constants for its index limits.
- One sub-module: capture_ram, a synchronous DEPTH x DW RAM with registered read and an out-of-range read returning 0.

Test Plan:
- Reset: hold rst=0 for 3 cycles mid-FILL → state=IDLE, count=0, full=0, s_ready=0, rd_data=0, ovf=0.
- Full capture: arm, then drive 5000 samples with s_data=i mod 256 continuously → start_out high for exactly 1 cycle, one cycle after sample 4999 is accepted; full=1; count=5000. Then rd_addr=0 → 0x00, rd_addr=4999 → 0x87 (−121) one cycle later, rd_addr=5001 → 0.
- Backpressure: s_valid toggled 1,0,0,1… → count advances only on s_valid=1 cycles; the stored order has no gaps.
- Overflow and release: in SERVE, drive s_valid=1 for one cycle → ovf=1 and sticky. Pulse corr_rdy → IDLE, full=0. Next arm → ovf=0.
- ena gating: ena=0 for 10 cycles during FILL with s_valid=1 → count unchanged, s_ready=0. With ena=1, filling resumes.
- CAP_TRIG_EN: send 5, −20, 31, −32, 40… → first three discarded; −32 (0xE0) stored at address 0; count=1 after it.

Source files
------------

// File: rtl/corr_pkg.sv
// Shared constants and types for the capture buffer and the correlation engine.
// TRIG_LEVEL only takes effect when the design is built with CAP_TRIG_EN defined.
package corr_pkg;

    localparam int DW         = 8;
    localparam int AW         = 13;
    localparam int DEPTH      = 5000;
    localparam int TRIG_LEVEL = 32;

    typedef logic signed [DW-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILL    = 2'd1,
        HANDOFF = 2'd2,
        SERVE   = 2'd3
    } cap_state_e;

    // The result is one bit wider than the sample, so -128 maps to +128.
    function automatic logic [DW:0] sample_mag(input sample_t s);
        logic [DW:0] ext;
        ext = {s[DW-1], s};
        if (s[DW-1]) begin
            return (DW+1)'(0) - ext;
        end else begin
            return ext;
        end
    endfunction

endpackage

// File: rtl/capture_ram.sv
// Synchronous DEPTH x DW sample RAM: one write port and one registered read port.
// A read outside the array, or a read while re is low, returns zero.
module capture_ram #(
    parameter int DEPTH = 5000,
    parameter int DW    = 8,
    parameter int AW    = 13
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_r [DEPTH];
    logic [DW-1:0] rdata_r;

    // The array has no reset, so synthesis can map it onto block RAM.
    always_ff @(posedge clk) begin
        if (ena && we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Read register with a synchronous clear on the output.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata_r <= {DW{1'b0}};
        end else if (ena) begin
            if (re && (raddr < AW'(DEPTH))) begin
                rdata_r <= mem_r[raddr];
            end else begin
                rdata_r <= {DW{1'b0}};
            end
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/sample_capture_buf.sv
// Re-armable sample capture buffer that feeds the correlator and serves its reads.
// Define CAP_TRIG_EN to discard samples below TRIG_LEVEL until the first one that reaches it.
module sample_capture_buf
    import corr_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic          arm,
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    output logic          s_ready,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    input  logic          corr_rdy,
    output logic          start_out,
    output logic          full,
    output logic [AW-1:0] count,
    output logic          ovf
);

    cap_state_e    state_r;
    logic          full_r;
    logic          ovf_r;
    logic [AW-1:0] count_r;
    logic          keep_s;
    logic          wr_en_s;
    logic          rd_en_s;
    logic          last_s;
`ifdef CAP_TRIG_EN
    logic          trig_seen_r;
`endif

    // Decide whether the offered sample is stored and whether reads are served.
    always_comb begin
        keep_s = 1'b1;
`ifdef CAP_TRIG_EN
        if (trig_seen_r) begin
            keep_s = 1'b1;
        end else if (sample_mag(sample_t'(s_data)) >= (DW+1)'(TRIG_LEVEL)) begin
            keep_s = 1'b1;
        end else begin
            keep_s = 1'b0;
        end
`endif
        if (ena && (state_r == FILL) && s_valid) begin
            wr_en_s = keep_s;
        end else begin
            wr_en_s = 1'b0;
        end
        // Stop serving on the release edge so rd_data is already zero in IDLE.
        if (state_r == HANDOFF) begin
            rd_en_s = 1'b1;
        end else if (state_r == SERVE) begin
            rd_en_s = !corr_rdy;
        end else begin
            rd_en_s = 1'b0;
        end
        last_s = (count_r == AW'(DEPTH - 1));
    end

    // Handshake and start pulse follow ena in the same cycle.
    always_comb begin
        s_ready   = ena && (state_r == FILL);
        start_out = ena && (state_r == HANDOFF);
    end

    // Capture state machine and its status registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= IDLE;
            count_r     <= {AW{1'b0}};
            full_r      <= 1'b0;
            ovf_r       <= 1'b0;
`ifdef CAP_TRIG_EN
            trig_seen_r <= 1'b0;
`endif
        end else if (ena) begin
            case (state_r)
                IDLE: begin
                    if (arm) begin
                        state_r     <= FILL;
                        count_r     <= {AW{1'b0}};
                        ovf_r       <= 1'b0;
`ifdef CAP_TRIG_EN
                        trig_seen_r <= 1'b0;
`endif
                    end
                end
                FILL: begin
                    if (wr_en_s) begin
                        count_r     <= count_r + AW'(1);
`ifdef CAP_TRIG_EN
                        trig_seen_r <= 1'b1;
`endif
                        if (last_s) begin
                            state_r <= HANDOFF;
                            full_r  <= 1'b1;
                        end
                    end
                end
                HANDOFF: begin
                    state_r <= SERVE;
                end
                SERVE: begin
                    if (s_valid) begin
                        ovf_r <= 1'b1;
                    end
                    if (corr_rdy) begin
                        state_r <= IDLE;
                        full_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    full_r  <= 1'b0;
                end
            endcase
        end
    end

    capture_ram #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .ena   (ena),
        .we    (wr_en_s),
        .waddr (count_r),
        .wdata (s_data),
        .re    (rd_en_s),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    assign full  = full_r;
    assign ovf   = ovf_r;
    assign count = count_r;

endmodule

// File: tb/tb_sample_capture_buf.sv
// Self-checking bench for sample_capture_buf: vector table, directed corner cases and
// randomized captures checked against a queue-based model of the stored samples.
module tb_sample_capture_buf;
    import corr_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          ena;
    logic          arm;
    logic          s_valid;
    logic [7:0]    s_data;
    logic          s_ready;
    logic [12:0]   rd_addr;
    logic [7:0]    rd_data;
    logic          corr_rdy;
    logic          start_out;
    logic          full;
    logic [12:0]   count;
    logic          ovf;

    int total = 0;
    int bad   = 0;
    logic [7:0] cap[$];
    bit trig_seen_m;

    typedef struct {
        bit         ena;
        bit         arm;
        bit         vld;
        logic [7:0] d;
        bit         exp_rdy;
        int         exp_cnt;
    } vec_t;
    vec_t tbl[11];

    sample_capture_buf dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .arm       (arm),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .corr_rdy  (corr_rdy),
        .start_out (start_out),
        .full      (full),
        .count     (count),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model rule: a sample is stored unless the trigger has not fired and |s| < 32.
    function automatic bit keeps(input logic [7:0] d);
`ifdef CAP_TRIG_EN
        int v;
        v = $signed(d);
        if (v < 0) v = -v;
        return trig_seen_m || (v >= 32);
`else
        return (d === d);
`endif
    endfunction

    task automatic do_fill(input int mode, input string tag);
        int cyc;
        int i;
        int pre[$];
        cyc = 0;
        i = 0;
        pre = '{5, -20, 31, -32, 40};
        cap.delete();
        trig_seen_m = 1'b0;
        ena = 1'b1; arm = 1'b1; s_valid = 1'b0; corr_rdy = 1'b0;
        step();
        arm = 1'b0;
        chk({tag, " arm count"}, count, 0);
        chk({tag, " arm ovf"}, ovf, 0);
        chk({tag, " arm full"}, full, 0);
        chk({tag, " arm s_ready"}, s_ready, 1);
        while (cap.size() < DEPTH && cyc < 20000) begin
            ena = 1'b1; s_valid = 1'b1; corr_rdy = 1'b0;
            rd_addr = 13'($urandom);
            s_data = 8'($urandom);
            case (mode)
                0: s_data = i[7:0];
                1: begin
                    s_valid = (cyc % 3 == 0);
                    if (cyc >= 100 && cyc < 110) ena = 1'b0;
                    if (cyc == 50) corr_rdy = 1'b1;
                end
                2: begin
                    s_valid = ($urandom_range(0, 3) != 0);
                    ena = ($urandom_range(0, 9) != 0);
                end
                3: if (i < pre.size()) s_data = 8'(pre[i]);
                default: s_valid = 1'b1;
            endcase
            #1;
            chk({tag, " fill s_ready"}, s_ready, ena);
            chk({tag, " fill start_out"}, start_out, 0);
            if (ena && s_valid) begin
                if (keeps(s_data)) begin
                    cap.push_back(s_data);
                    trig_seen_m = 1'b1;
                end
                i++;
            end
            step();
            chk({tag, " fill count"}, count, cap.size());
            chk({tag, " fill rd_data"}, rd_data, 0);
            if (mode == 3 && i == 3) chk({tag, " trig discards"}, count, 0);
            if (mode == 3 && i == 4) chk({tag, " trig first store"}, count, 1);
            cyc++;
        end
        if (cyc >= 20000) begin
            total++; bad++;
            $display("FAIL %s fill timeout: got %0d samples expected %0d", tag, cap.size(), DEPTH);
        end
        s_valid = 1'b0; corr_rdy = 1'b0; ena = 1'b1;
        if (mode == 2) begin
            ena = 1'b0;
            #1;
            chk({tag, " handoff ena0 start"}, start_out, 0);
            step();
            chk({tag, " handoff ena0 hold"}, start_out, 0);
            chk({tag, " handoff ena0 full"}, full, 1);
            ena = 1'b1;
        end
        #1;
        chk({tag, " start_out"}, start_out, 1);
        chk({tag, " handoff full"}, full, 1);
        chk({tag, " handoff count"}, count, DEPTH);
        chk({tag, " handoff s_ready"}, s_ready, 0);
        step();
        chk({tag, " start_out 1 cycle"}, start_out, 0);
        chk({tag, " serve full"}, full, 1);
        chk({tag, " serve s_ready"}, s_ready, 0);
        chk({tag, " serve ovf"}, ovf, 0);
    endtask

    task automatic do_reads(input int n, input string tag);
        int fa[5];
        int addr;
        logic [7:0] e;
        fa = '{0, DEPTH - 1, DEPTH, DEPTH + 1, 8191};
        s_valid = 1'b0; corr_rdy = 1'b0; ena = 1'b1;
        for (int k = 0; k < n + 5; k++) begin
            if (k < 5) addr = fa[k];
            else if (k % 2 == 1) addr = $urandom_range(0, DEPTH - 1);
            else addr = $urandom_range(0, 8191);
            rd_addr = 13'(addr);
            step();
            e = (addr < DEPTH) ? cap[addr] : 8'h00;
            chk({tag, " rd_data"}, rd_data, e);
        end
    endtask

    task automatic release_buf(input string tag);
        corr_rdy = 1'b1;
        step();
        corr_rdy = 1'b0;
        chk({tag, " release full"}, full, 0);
        chk({tag, " release s_ready"}, s_ready, 0);
        chk({tag, " release rd_data"}, rd_data, 0);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 0};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 8'h22, 1'b0, 0};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 8'h33, 1'b0, 0};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 8'h50, 1'b1, 1};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 8'hC0, 1'b1, 2};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 8'h99, 1'b0, 2};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 8'h60, 1'b1, 3};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 8'h70, 1'b1, 4};

        rst = 1'b0; ena = 1'b1; arm = 1'b0; s_valid = 1'b0; s_data = 8'h00;
        rd_addr = 13'd0; corr_rdy = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        #1;
        chk("por count", count, 0);
        chk("por full", full, 0);
        chk("por s_ready", s_ready, 0);
        chk("por start_out", start_out, 0);
        chk("por ovf", ovf, 0);
        chk("por rd_data", rd_data, 0);

        for (int r = 0; r < 11; r++) begin
            ena = tbl[r].ena; arm = tbl[r].arm; s_valid = tbl[r].vld; s_data = tbl[r].d;
            #1;
            chk($sformatf("vec%0d s_ready", r), s_ready, tbl[r].exp_rdy);
            step();
            chk($sformatf("vec%0d count", r), count, tbl[r].exp_cnt);
            chk($sformatf("vec%0d ovf", r), ovf, 0);
        end

        // Reset in the middle of a capture, with arm held high during it.
        ena = 1'b1; arm = 1'b1; s_valid = 1'b1; rst = 1'b0;
        repeat (3) step();
        rst = 1'b1; arm = 1'b0; s_valid = 1'b0;
        #1;
        chk("midfill rst count", count, 0);
        chk("midfill rst full", full, 0);
        chk("midfill rst s_ready", s_ready, 0);
        chk("midfill rst rd_data", rd_data, 0);
        chk("midfill rst ovf", ovf, 0);
        step();
        chk("rst no arm kept", s_ready, 0);

        do_fill(0, "ramp");
`ifndef CAP_TRIG_EN
        rd_addr = 13'd0;    step(); chk("ramp addr0", rd_data, 8'h00);
        rd_addr = 13'd4999; step(); chk("ramp addr4999", rd_data, 8'h87);
        rd_addr = 13'd5001; step(); chk("ramp addr5001", rd_data, 8'h00);
`endif
        do_reads(60, "ramp");

        // Overflow is sticky; ena=0 blocks release; arm with corr_rdy is dropped.
        s_valid = 1'b1; step(); s_valid = 1'b0;
        chk("ovf set", ovf, 1);
        chk("ovf full", full, 1);
        step(); step();
        chk("ovf sticky", ovf, 1);
        ena = 1'b0; corr_rdy = 1'b1; step();
        chk("ena0 no release", full, 1);
        ena = 1'b1; arm = 1'b1; corr_rdy = 1'b1; step();
        arm = 1'b0; corr_rdy = 1'b0;
        chk("arm+rdy full", full, 0);
        chk("arm+rdy rd_data", rd_data, 0);
        chk("arm+rdy count held", count, DEPTH);
        chk("arm+rdy ovf held", ovf, 1);
        step();
        chk("arm dropped", s_ready, 0);
        chk("idle count held", count, DEPTH);

        do_fill(1, "bp");
        do_reads(60, "bp");
        release_buf("bp");

        do_fill(2, "rnd");
        do_reads(60, "rnd");
        release_buf("rnd");

`ifdef CAP_TRIG_EN
        do_fill(3, "trig");
        rd_addr = 13'd0; step(); chk("trig addr0", rd_data, 8'hE0);
        rd_addr = 13'd1; step(); chk("trig addr1", rd_data, 8'd40);
        release_buf("trig");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
